// File: rtl/lbus_cmd_seq.sv
// Byte-stream command sequencer: parses write/read commands from an RX FIFO,
// drives a simple local bus, and returns read data through a TX FIFO.
module lbus_cmd_seq #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_d,
  output logic        rx_re,
  input  logic        rx_emp,
  input  logic        rx_aemp,
  output logic [7:0]  tx_d,
  output logic        tx_we,
  input  logic        tx_ful,
  input  logic        tx_aful,
  output logic [15:0] lbus_a,
  output logic [15:0] lbus_di,
  output logic        lbus_wr,
  output logic        lbus_rd,
  input  logic [15:0] lbus_do,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    StCmd,
    StArg,
    StExecWr,
    StExecRd,
    StRdWait,
    StTxHi,
    StTxLo
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic        op_rd_q, op_rd_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        rx_re_q, rx_re_d;
  logic        byte_vld_q, byte_vld_d;
  logic        tx_we_q, tx_we_d;
  logic [7:0]  tx_d_q, tx_d_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] hold_q, hold_d;
  logic        err_q, err_d;

  logic rx_busy;
  logic tx_busy;
  logic fetch_ok;

  // FIFO flow control; strobes are registered so these never loop back combinationally.
  assign rx_busy = rx_emp | (rx_aemp & rx_re_q);
  assign tx_busy = tx_ful | (tx_aful & tx_we_q);

  // Next-state, byte capture, timeout and strobe decisions.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    op_rd_d    = op_rd_q;
    to_cnt_d   = to_cnt_q;
    tx_d_d     = tx_d_q;
    addr_d     = addr_q;
    data_d     = data_q;
    hold_d     = hold_q;
    err_d      = 1'b0;
    tx_we_d    = 1'b0;
    byte_vld_d = rx_re_q;
    fetch_ok   = 1'b0;
    rx_re_d    = 1'b0;

    unique case (state_q)
      StCmd: begin
        if (byte_vld_q) begin
          if (rx_d == 8'h00 || rx_d == 8'h01) begin
            op_rd_d  = rx_d[0];
            bcnt_d   = 2'd0;
            to_cnt_d = 16'd0;
            state_d  = StArg;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StArg: begin
        if (byte_vld_q) begin
          unique case (bcnt_q)
            2'd0: addr_d[15:8] = rx_d;
            2'd1: addr_d[7:0]  = rx_d;
            2'd2: data_d[15:8] = rx_d;
            2'd3: data_d[7:0]  = rx_d;
            default: ;
          endcase
          to_cnt_d = 16'd0;
          if (op_rd_q && bcnt_q == 2'd1) begin
            state_d = StExecRd;
          end else if (bcnt_q == 2'd3) begin
            state_d = StExecWr;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end else if (to_cnt_q >= TIMEOUT && !rx_re_q) begin
          // Only abort when no byte is in flight, so a late byte is never misread.
          err_d    = 1'b1;
          to_cnt_d = 16'd0;
          state_d  = StCmd;
        end else if (to_cnt_q < TIMEOUT) begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      StExecWr: state_d = StCmd;
      StExecRd: state_d = StRdWait;
      StRdWait: begin
        hold_d  = lbus_do;
        state_d = StTxHi;
      end
      StTxHi: begin
        if (!tx_busy && !tx_we_q) begin
          tx_we_d = 1'b1;
          tx_d_d  = hold_q[15:8];
          state_d = StTxLo;
        end
      end
      StTxLo: begin
        if (!tx_busy && !tx_we_q) begin
          tx_we_d = 1'b1;
          tx_d_d  = hold_q[7:0];
          state_d = StCmd;
        end
      end
      default: state_d = StCmd;
    endcase

    // Next strobe is issued only if the following cycle still fetches and no
    // other strobe (the final TX write) claims that cycle.
    fetch_ok = (state_d == StCmd) || (state_d == StArg);
    rx_re_d  = fetch_ok && !rx_busy && !rx_re_q && !tx_we_d;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StCmd;
      bcnt_q     <= 2'd0;
      op_rd_q    <= 1'b0;
      to_cnt_q   <= 16'd0;
      rx_re_q    <= 1'b0;
      byte_vld_q <= 1'b0;
      tx_we_q    <= 1'b0;
      tx_d_q     <= 8'h00;
      addr_q     <= 16'h0000;
      data_q     <= 16'h0000;
      hold_q     <= 16'h0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      op_rd_q    <= op_rd_d;
      to_cnt_q   <= to_cnt_d;
      rx_re_q    <= rx_re_d;
      byte_vld_q <= byte_vld_d;
      tx_we_q    <= tx_we_d;
      tx_d_q     <= tx_d_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
    end
  end

  // Output mapping; busy also covers the last TX write, which lands after returning to CMD.
  always_comb begin
    rx_re   = rx_re_q;
    tx_we   = tx_we_q;
    tx_d    = tx_d_q;
    lbus_a  = addr_q;
    lbus_di = data_q;
    lbus_wr = (state_q == StExecWr);
    lbus_rd = (state_q == StExecRd);
    err     = err_q;
    busy    = (state_q != StCmd) || tx_we_q;
  end

endmodule

// File: tb/tb_lbus_cmd_seq.sv
// Directed bench for lbus_cmd_seq: FIFO/bus models, vector table, corner sequences.
module tb_lbus_cmd_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_d = 8'h00;
  logic        rx_re;
  logic        rx_emp = 1'b1;
  logic        rx_aemp = 1'b0;
  logic [7:0]  tx_d;
  logic        tx_we;
  logic        tx_ful = 1'b0;
  logic        tx_aful = 1'b0;
  logic [15:0] lbus_a;
  logic [15:0] lbus_di;
  logic        lbus_wr;
  logic        lbus_rd;
  logic [15:0] lbus_do = 16'h0000;
  logic        err;
  logic        busy;

  lbus_cmd_seq #(.TIMEOUT(16'd8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx_d    (rx_d),
    .rx_re   (rx_re),
    .rx_emp  (rx_emp),
    .rx_aemp (rx_aemp),
    .tx_d    (tx_d),
    .tx_we   (tx_we),
    .tx_ful  (tx_ful),
    .tx_aful (tx_aful),
    .lbus_a  (lbus_a),
    .lbus_di (lbus_di),
    .lbus_wr (lbus_wr),
    .lbus_rd (lbus_rd),
    .lbus_do (lbus_do),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [15:0] rd_val = 16'h0000;
  int          rx_re_cnt, wr_cnt, rd_cnt, err_cnt;
  int          prot_err = 0;
  logic [15:0] last_wr_a, last_wr_di, last_rd_a;
  logic        prev_rx_re = 1'b0;
  logic        prev_tx_we = 1'b0;

  typedef struct {
    logic [47:0] bytes;
    int          n;
    logic [15:0] rdv;
    int          nwr;
    logic [15:0] wa;
    logic [15:0] wd;
    int          nrd;
    logic [15:0] ra;
    int          ntx;
    logic [15:0] txw;
    int          nerr;
    logic [15:0] a_end;
    logic [15:0] di_end;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void upd_flags();
    rx_emp  = (rxq.size() == 0);
    rx_aemp = (rxq.size() == 1);
  endfunction

  task automatic push(input logic [7:0] b);
    rxq.push_back(b);
    upd_flags();
  endtask

  function automatic logic [15:0] tx_word();
    logic [15:0] w = 16'h0000;
    if (txq.size() > 0) w[15:8] = txq[0];
    if (txq.size() > 1) w[7:0] = txq[1];
    return w;
  endfunction

  task automatic clear_mon();
    rx_re_cnt  = 0;
    wr_cnt     = 0;
    rd_cnt     = 0;
    err_cnt    = 0;
    last_wr_a  = 16'h0000;
    last_wr_di = 16'h0000;
    last_rd_a  = 16'h0000;
    txq.delete();
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 6 && n < 300) begin
      @(negedge clk);
      #1;
      quiet = (rxq.size() == 0 && !busy && !rx_re) ? quiet + 1 : 0;
      n++;
    end
    chk({tag, " idle"}, 32'(quiet >= 6), 32'd1);
  endtask

  // FIFO / local-bus models and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_rx_re = 1'b0;
      prev_tx_we = 1'b0;
    end else begin
      if ((int'(rx_re) + int'(tx_we) + int'(lbus_wr) + int'(lbus_rd)) > 1) prot_err++;
      if (rx_re) begin
        rx_re_cnt++;
        if (prev_rx_re) prot_err++;
        if (rxq.size() == 0) prot_err++;
        else rx_d = rxq.pop_front();
      end
      if (tx_we) begin
        if (prev_tx_we || tx_ful || !busy) prot_err++;
        txq.push_back(tx_d);
      end
      if (lbus_wr) begin
        wr_cnt++;
        last_wr_a  = lbus_a;
        last_wr_di = lbus_di;
      end
      if (lbus_rd) begin
        rd_cnt++;
        last_rd_a = lbus_a;
        lbus_do   = rd_val;
      end
      if (err) err_cnt++;
      prev_rx_re = rx_re;
      prev_tx_we = tx_we;
      upd_flags();
    end
  end

  initial begin
    logic [7:0] tx_d0;
    int         n;
    int         we_seen;
    int         d_changes;

    vecs[0] = '{48'h0012_34AB_CD00, 5, 16'h0000, 1, 16'h1234, 16'hABCD, 0, 16'h0000,
                0, 16'h0000, 0, 16'h1234, 16'hABCD};
    vecs[1] = '{48'h0100_1000_0000, 3, 16'h5A5A, 0, 16'h0000, 16'h0000, 1, 16'h0010,
                2, 16'h5A5A, 0, 16'h0010, 16'hABCD};
    vecs[2] = '{48'h7F00_1234_ABCD, 6, 16'h0000, 1, 16'h1234, 16'hABCD, 0, 16'h0000,
                0, 16'h0000, 1, 16'h1234, 16'hABCD};
    vecs[3] = '{48'h01BE_EF00_0000, 3, 16'h8421, 0, 16'h0000, 16'h0000, 1, 16'hBEEF,
                2, 16'h8421, 0, 16'hBEEF, 16'hABCD};
    vecs[4] = '{48'h00FF_FF00_0100, 5, 16'h0000, 1, 16'hFFFF, 16'h0001, 0, 16'h0000,
                0, 16'h0000, 0, 16'hFFFF, 16'h0001};

    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    chk("reset strobes", {24'd0, rx_re, tx_we, lbus_wr, lbus_rd, err, busy, 2'b00}, 32'd0);
    chk("reset tx_d", {24'd0, tx_d}, 32'd0);
    chk("reset bus", {lbus_a, lbus_di}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Table-driven commands.
    for (int v = 0; v < 5; v++) begin
      @(posedge clk);
      #1;
      clear_mon();
      rd_val  = vecs[v].rdv;
      lbus_do = 16'h0000;
      for (int k = 0; k < vecs[v].n; k++) push(vecs[v].bytes[47-8*k -: 8]);
      wait_idle($sformatf("v%0d", v));
      chk($sformatf("v%0d nwr", v), wr_cnt, vecs[v].nwr);
      chk($sformatf("v%0d wr_a", v), {16'd0, last_wr_a}, {16'd0, vecs[v].wa});
      chk($sformatf("v%0d wr_di", v), {16'd0, last_wr_di}, {16'd0, vecs[v].wd});
      chk($sformatf("v%0d nrd", v), rd_cnt, vecs[v].nrd);
      chk($sformatf("v%0d rd_a", v), {16'd0, last_rd_a}, {16'd0, vecs[v].ra});
      chk($sformatf("v%0d ntx", v), txq.size(), vecs[v].ntx);
      chk($sformatf("v%0d tx bytes", v), {16'd0, tx_word()}, {16'd0, vecs[v].txw});
      chk($sformatf("v%0d nerr", v), err_cnt, vecs[v].nerr);
      chk($sformatf("v%0d rx_re", v), rx_re_cnt, vecs[v].n);
      chk($sformatf("v%0d hold a/di", v), {lbus_a, lbus_di}, {vecs[v].a_end, vecs[v].di_end});
    end

    // Timeout: partial command then silence; the next 01 must act as an opcode.
    @(posedge clk);
    #1;
    clear_mon();
    push(8'h00);
    push(8'h12);
    n = 0;
    while (err_cnt == 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("timeout err seen", 32'(err_cnt), 32'd1);
    wait_idle("timeout");
    chk("timeout err once", err_cnt, 1);
    chk("timeout no bus", wr_cnt + rd_cnt, 0);
    @(posedge clk);
    #1;
    rd_val = 16'h1357;
    push(8'h01);
    push(8'h00);
    push(8'h10);
    wait_idle("after timeout");
    chk("post-timeout nrd", rd_cnt, 1);
    chk("post-timeout rd_a", {16'd0, last_rd_a}, 32'h0010);
    chk("post-timeout tx", {16'd0, tx_word()}, 32'h1357);
    chk("post-timeout nwr", wr_cnt, 0);

    // Backpressure: TX FIFO full while a read result is pending.
    @(posedge clk);
    #1;
    clear_mon();
    tx_ful = 1'b1;
    rd_val = 16'hC3A5;
    push(8'h01);
    push(8'hAB);
    push(8'hCD);
    n = 0;
    while (rd_cnt == 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("bp read issued", 32'(rd_cnt), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    tx_d0     = tx_d;
    we_seen   = 0;
    d_changes = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (tx_we) we_seen++;
      if (tx_d !== tx_d0) d_changes++;
    end
    chk("bp tx_we held", we_seen, 0);
    chk("bp tx_d stable", d_changes, 0);
    chk("bp busy", {31'd0, busy}, 32'd1);
    chk("bp rd_a", {16'd0, last_rd_a}, 32'hABCD);
    tx_ful = 1'b0;
    wait_idle("bp");
    chk("bp ntx", txq.size(), 2);
    chk("bp tx order", {16'd0, tx_word()}, 32'hC3A5);

    // Single queued byte with almost-empty asserted.
    @(posedge clk);
    #1;
    clear_mon();
    push(8'h7F);
    wait_idle("aemp");
    chk("aemp one rx_re", rx_re_cnt, 1);
    chk("aemp err", err_cnt, 1);

    // Asynchronous reset in the middle of an argument fetch.
    @(posedge clk);
    #1;
    clear_mon();
    push(8'h00);
    push(8'h12);
    push(8'h34);
    n = 0;
    while (rx_re_cnt < 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst in ARG busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst async strobes", {24'd0, rx_re, tx_we, lbus_wr, lbus_rd, err, busy, 2'b00}, 32'd0);
    chk("rst async bus", {lbus_a, lbus_di}, 32'd0);
    chk("rst async tx_d", {24'd0, tx_d}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    clear_mon();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst release rx_re", {31'd0, rx_re}, 32'd0);
    wait_idle("post reset");
    chk("post reset nwr", wr_cnt, 0);
    chk("post reset leftover err", err_cnt, 1);
    chk("post reset rx_re", rx_re_cnt, 1);

    chk("protocol", prot_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
